// File: rtl/pdm_serializer_pkg.sv
// Shared constants and state encoding for the PDM serializer.
// Word width must match the microphone-side deserializer.
package pdm_serializer_pkg;

    localparam int PDM_WIDTH       = 32;
    localparam int PDM_DIV_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // First idle bit after reset or after an underrun; yields 0101... (zero PCM level).
    localparam logic IDLE_BIT_RESET = 1'b0;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM bit clock generator: divides clk by DIV into a 50% duty pdm_clk
// and flags the edge on which pdm_clk falls (the bit tick).
module pdm_clk_gen
    import pdm_serializer_pkg::*;
#(
    parameter int DIV = PDM_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic pdm_clk,
    output logic tick
);

    localparam int            CW       = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Tick is decoded from the registered count so that the consumer registers
    // pdm_out on the same edge that drops pdm_clk.
    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt     <= '0;
            pdm_clk <= 1'b0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_MID) begin
                pdm_clk <= 1'b1;
            end else if (cnt == CNT_LAST) begin
                pdm_clk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pdm_serializer.sv
// Parallel-to-serial PDM transmitter with a one-word holding register.
//   state   | meaning
//   ST_IDLE | no word shifting; emits the 0101... idle pattern each tick
//   ST_RUN  | shifting a word MSB first; reloads from hold at word boundary
module pdm_serializer
    import pdm_serializer_pkg::*;
#(
    parameter int DIV   = PDM_DIV_DEFAULT,
    parameter int WIDTH = PDM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pdm_clk,
    output logic             pdm_out,
    output logic             bit_tick,
    output logic             word_done,
    output logic             underrun,
    output logic             busy
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic             idle_bit;
    logic             tick;

    pdm_clk_gen #(
        .DIV (DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pdm_clk (pdm_clk),
        .tick    (tick)
    );

    assign in_ready = !hold_full;
    assign busy     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        bit_tick  <= 1'b0;
        word_done <= 1'b0;
        underrun  <= 1'b0;
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            idle_bit  <= IDLE_BIT_RESET;
            pdm_out   <= 1'b0;
        end else begin
            // Holding register keeps accepting even while the transmitter is disabled.
            if (in_valid && !hold_full) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end

            if (!en) begin
                state   <= ST_IDLE;
                shreg   <= '0;
                bit_cnt <= '0;
                pdm_out <= 1'b0;
            end else if (tick) begin
                bit_tick <= 1'b1;
                if (state == ST_RUN && bit_cnt != LAST_BIT) begin
                    pdm_out <= shreg[WIDTH-1];
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    if (state == ST_RUN) begin
                        word_done <= 1'b1;
                    end
                    if (hold_full) begin
                        // Shifter stores the remaining bits pre-aligned to the MSB.
                        pdm_out   <= hold_data[WIDTH-1];
                        shreg     <= {hold_data[WIDTH-2:0], 1'b0};
                        bit_cnt   <= BW'(1);
                        hold_full <= 1'b0;
                        state     <= ST_RUN;
                    end else if (state == ST_RUN) begin
                        underrun <= 1'b1;
                        state    <= ST_IDLE;
                        pdm_out  <= IDLE_BIT_RESET;
                        idle_bit <= ~IDLE_BIT_RESET;
                    end else begin
                        pdm_out  <= idle_bit;
                        idle_bit <= ~idle_bit;
                    end
                end
            end
        end
    end

endmodule
